// File: rtl/dp_pkg.sv
// Shared datapath definitions: ALU op encodings, status flag positions and
// overflow helpers used by the ALU stage.
package dp_pkg;

    localparam int DP_WIDTH = 16;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_AND  = 2'b10,
        ALU_NOTB = 2'b11
    } alu_op_e;

    // status is packed as {V,N,Z}
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;

    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: result and {V,N,Z} flags for one operand pair.
module alu_core
    import dp_pkg::*;
#(
    parameter int WIDTH = DP_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       aluop,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags
);

    logic [WIDTH-1:0] result_s;
    logic             ovf_s;

    // Operation select and overflow detection
    always_comb begin
        result_s = {WIDTH{1'b0}};
        ovf_s    = 1'b0;
        case (aluop)
            ALU_ADD: begin
                result_s = a + b;
                ovf_s    = add_ovf(a[WIDTH-1], b[WIDTH-1], result_s[WIDTH-1]);
            end
            ALU_SUB: begin
                result_s = a - b;
                ovf_s    = sub_ovf(a[WIDTH-1], b[WIDTH-1], result_s[WIDTH-1]);
            end
            ALU_AND: begin
                result_s = a & b;
                ovf_s    = 1'b0;
            end
            ALU_NOTB: begin
                result_s = ~b;
                ovf_s    = 1'b0;
            end
            default: begin
                result_s = {WIDTH{1'b0}};
                ovf_s    = 1'b0;
            end
        endcase
    end

    // Flag packing from the computed result
    always_comb begin
        flags         = 3'b000;
        flags[FLAG_Z] = (result_s == {WIDTH{1'b0}});
        flags[FLAG_N] = result_s[WIDTH-1];
        flags[FLAG_V] = ovf_s;
    end

    assign result = result_s;

endmodule

// File: rtl/alu_stage.sv
// Single-entry ALU pipeline stage with valid/ready handshake on both sides,
// registered result, status flags and an accepted-operation counter.
module alu_stage
    import dp_pkg::*;
#(
    parameter int WIDTH = DP_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic [1:0]       aluop,
    input  logic             in_loads,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_c,
    output logic [2:0]       status,
    output logic [7:0]       op_count
);

    logic [WIDTH-1:0] result_s;
    logic [2:0]       flags_s;
    logic             accept_s;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_c_r;
    logic [2:0]       status_r;
    logic [7:0]       op_count_r;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a      (ain),
        .b      (bin),
        .aluop  (aluop),
        .result (result_s),
        .flags  (flags_s)
    );

    // Ready whenever the output slot is empty or is being drained this cycle
    assign in_ready = !out_valid_r || out_ready;
    assign accept_s = in_valid && in_ready;

    // Output slot, status flags and operation counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            out_c_r     <= {WIDTH{1'b0}};
            status_r    <= 3'b000;
            op_count_r  <= 8'd0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_c_r     <= result_s;
            op_count_r  <= op_count_r + 8'd1;
            if (in_loads) begin
                status_r <= flags_s;
            end else begin
                status_r <= status_r;
            end
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_c     = out_c_r;
    assign status    = status_r;
    assign op_count  = op_count_r;

endmodule

// File: tb/tb_alu_stage.sv
// Self-checking bench for alu_stage: vector table streamed through a
// scoreboard queue, plus stall, reset and counter-wrap sequences.
module tb_alu_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ain;
    logic [15:0] bin;
    logic [1:0]  aluop;
    logic        in_loads;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_c;
    logic [2:0]  status;
    logic [7:0]  op_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic        ld;
        logic [15:0] c;
        logic [2:0]  st;
    } vec_t;

    typedef struct {
        logic [15:0] c;
        logic [2:0]  st;
    } exp_t;

    vec_t        vecs[10];
    exp_t        sb[$];
    logic [2:0]  status_m;
    logic [7:0]  cnt_m;

    alu_stage #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ain       (ain),
        .bin       (bin),
        .aluop     (aluop),
        .in_loads  (in_loads),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .status    (status),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model using signed integer arithmetic for overflow
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                         output logic [15:0] c, output logic [2:0] fl);
        int sa, sb2, s;
        logic v;
        sa  = int'($signed(a));
        sb2 = int'($signed(b));
        v   = 1'b0;
        case (op)
            2'b00: begin s = sa + sb2; v = (s > 32767) || (s < -32768); c = a + b; end
            2'b01: begin s = sa - sb2; v = (s > 32767) || (s < -32768); c = a - b; end
            2'b10: c = a & b;
            default: c = ~b;
        endcase
        fl = {v, c[15], (c == 16'h0000)};
    endtask

    // One cycle: drive, score delivery/acceptance, advance past next edge
    task automatic cycle(input logic iv, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op, input logic ld, input logic ordy,
                         input logic [15:0] ec, input logic [2:0] efl);
        exp_t e;
        in_valid  = iv;
        ain       = a;
        bin       = b;
        aluop     = op;
        in_loads  = ld;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out_c", {16'h0, out_c}, {16'h0, e.c});
                chk("status", {29'h0, status}, {29'h0, e.st});
            end
        end
        if (in_valid && in_ready) begin
            if (ld) status_m = efl;
            e.c  = ec;
            e.st = status_m;
            sb.push_back(e);
            cnt_m = cnt_m + 8'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, ordy, 16'h0, 3'b000);
    endtask

    initial begin
        logic [15:0] ra, rb, rc;
        logic [1:0]  rop;
        logic [2:0]  rfl;

        vecs[0] = '{16'h7FFF, 16'h0001, 2'b00, 1'b1, 16'h8000, 3'b110};
        vecs[1] = '{16'h1234, 16'h1234, 2'b01, 1'b0, 16'h0000, 3'b001};
        vecs[2] = '{16'hAAAA, 16'h0F0F, 2'b10, 1'b1, 16'h0A0A, 3'b000};
        vecs[3] = '{16'h5555, 16'h00FF, 2'b11, 1'b1, 16'hFF00, 3'b010};
        vecs[4] = '{16'h8000, 16'h0001, 2'b01, 1'b1, 16'h7FFF, 3'b100};
        vecs[5] = '{16'hFFFF, 16'h0001, 2'b00, 1'b1, 16'h0000, 3'b001};
        vecs[6] = '{16'h0003, 16'h0005, 2'b01, 1'b1, 16'hFFFE, 3'b010};
        vecs[7] = '{16'h1234, 16'h0000, 2'b10, 1'b0, 16'h0000, 3'b001};
        vecs[8] = '{16'h0000, 16'hFFFF, 2'b11, 1'b1, 16'h0000, 3'b001};
        vecs[9] = '{16'h4000, 16'h4000, 2'b00, 1'b1, 16'h8000, 3'b110};

        status_m  = 3'b000;
        cnt_m     = 8'd0;
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        ain       = 16'h1111;
        bin       = 16'h2222;
        aluop     = 2'b00;
        in_loads  = 1'b1;
        out_ready = 1'b0;

        // Reset held across edges with in_valid high: nothing may be accepted
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_out_c", {16'h0, out_c}, 32'd0);
        chk("rst_status", {29'h0, status}, 32'd0);
        chk("rst_op_count", {24'h0, op_count}, 32'd0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        #1;
        chk("rel_in_ready", {31'h0, in_ready}, 32'd1);

        // Back-to-back stream, out_ready held high
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].ld, 1'b1,
                  vecs[i].c, vecs[i].ld ? vecs[i].st : status_m);
            chk("stream_valid", {31'h0, out_valid}, 32'd1);
        end
        chk("stream_count", {24'h0, op_count}, {24'h0, cnt_m});
        idle(1'b1);
        chk("drain_valid", {31'h0, out_valid}, 32'd0);
        chk("drain_sb", sb.size(), 32'd0);

        // Stall: result held, new requests refused for 5 cycles
        cycle(1'b1, 16'h0005, 16'h0003, 2'b00, 1'b1, 1'b0, 16'h0008, 3'b000);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 16'hFFFF, 16'hFFFF, 2'b01, 1'b1, 1'b0, 16'h0000, 3'b001);
            chk("stall_in_ready", {31'h0, in_ready}, 32'd0);
            chk("stall_out_c", {16'h0, out_c}, 32'h0008);
            chk("stall_count", {24'h0, op_count}, {24'h0, cnt_m});
        end

        // Reset asserted mid-stall clears everything immediately
        reset_n = 1'b0;
        #1;
        chk("mid_out_valid", {31'h0, out_valid}, 32'd0);
        chk("mid_out_c", {16'h0, out_c}, 32'd0);
        chk("mid_status", {29'h0, status}, 32'd0);
        chk("mid_op_count", {24'h0, op_count}, 32'd0);
        chk("mid_in_ready", {31'h0, in_ready}, 32'd1);
        sb.delete();
        cnt_m    = 8'd0;
        status_m = 3'b000;
        @(posedge clk);
        #1;
        chk("mid_edge_count", {24'h0, op_count}, 32'd0);
        reset_n  = 1'b1;
        in_valid = 1'b0;

        // 256 accepted ops wrap the counter; last op is NOTB of 00FF
        for (int i = 0; i < 256; i++) begin
            ra  = 16'($urandom);
            rb  = (i == 255) ? 16'h00FF : 16'($urandom);
            rop = (i == 255) ? 2'b11 : 2'($urandom_range(0, 3));
            model(ra, rb, rop, rc, rfl);
            cycle(1'b1, ra, rb, rop, 1'b1, 1'b1, rc, rfl);
        end
        chk("wrap_count", {24'h0, op_count}, 32'd0);
        chk("notb_out_c", {16'h0, out_c}, 32'h0000FF00);
        chk("notb_v", {31'h0, status[2]}, 32'd0);
        idle(1'b1);
        chk("final_sb", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/alu_stage.md
ALU_STAGE -- requirements
Module: alu_stage

Interface
REQ-001 SHALL have parameter: WIDTH, 16, datapath width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: in_valid  input  1  operand pair and op valid this cycle.
REQ-005 SHALL have port: in_ready  output  1  stage can accept an operation this cycle.
REQ-006 SHALL have port: ain  input  WIDTH  operand A (A register output).
REQ-007 SHALL have port: bin  input  WIDTH  operand B, taken directly from shifter output sout.
REQ-008 SHALL have port: aluop  input  2  operation select.
REQ-009 SHALL have port: in_loads  input  1  update status flags with this operation.
REQ-010 SHALL have port: out_valid  output  1  out_c holds an undelivered result.
REQ-011 SHALL have port: out_ready  input  1  consumer (writeback / C register) takes result.
REQ-012 SHALL have port: out_c  output  WIDTH  registered result.
REQ-013 SHALL have port: status  output  3  registered flags {V,N,Z}.
REQ-014 SHALL have port: op_count  output  8  count of accepted operations.

Function
REQ-015 SHALL compute: aluop 00 -> A+B mod 2^WIDTH; 01 -> A-B mod 2^WIDTH; 10 -> A&B; 11 -> ~B.
REQ-016 SHALL derive flags from the computed result: Z = result==0; N = result[WIDTH-1]; V = two's-complement overflow for 00/01, 0 for 10/11.
REQ-017 SHALL drive in_ready = !out_valid || out_ready, combinationally, with no dependency on in_valid.
REQ-018 SHALL accept an operation exactly when in_valid && in_ready at a rising edge.
REQ-019 SHALL present the result with latency 1: accepted at edge k -> out_c valid and out_valid=1 immediately after edge k.
REQ-020 SHALL deliver a result when out_valid && out_ready at a rising edge; out_valid clears unless a new op is accepted at the same edge.
REQ-021 SHALL, on simultaneous delivery and acceptance, load the new result with out_valid remaining 1 (full throughput, no bubble).
REQ-022 SHALL hold out_c stable while out_valid=1 and out_ready=0; ain/bin/aluop changes are ignored.
REQ-023 SHALL ignore in_valid while in_ready=0 (no accept, no flag or counter change).
REQ-024 SHALL update status only on an accepted op with in_loads=1, in the same edge out_c loads; otherwise hold.
REQ-025 SHALL increment op_count by 1 on every accepted op, wrapping 255 -> 0.
REQ-026 SHALL keep outputs free of X when in_valid=0 regardless of ain/bin/aluop values.

Reset
REQ-027 SHALL, on reset_n=0, asynchronously force out_valid=0, out_c=0, status=3'b000, op_count=0.
REQ-028 SHALL discard any held undelivered result if reset asserts mid-operation; in_ready=1 while reset_n=0 and first cycle after release.
REQ-029 SHALL accept no operation on the edge at which reset_n is sampled low.

Structure
REQ-030 SHALL take ALU op encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_NOTB), flag bit indices and default WIDTH from shared package dp_pkg.
REQ-031 SHALL place result and flag computation in a combinational sub-module alu_core; alu_stage holds handshake, registers and counter.

Verification
REQ-032 SHALL verify: reset_n low mid-stall with out_valid=1 -> out_valid=0, out_c=0, status=000, op_count=0 immediately.
REQ-033 SHALL verify: ain=16'h7FFF, bin=16'h0001, aluop=00, in_loads=1, out_ready=1 -> out_c=16'h8000, status V=1,N=1,Z=0 one cycle later.
REQ-034 SHALL verify: ain=16'h1234, bin=16'h1234, aluop=01, in_loads=0 -> out_c=0, status unchanged from prior value.
REQ-035 SHALL verify: out_ready=0 with out_valid=1, new in_valid=1 -> in_ready=0, out_c held, op_count unchanged over 5 cycles.
REQ-036 SHALL verify: back-to-back 4 ops with out_ready=1 continuously -> one result per cycle, out_valid never drops, op_count +4.
REQ-037 SHALL verify: 256 accepted ops from reset -> op_count returns to 0; aluop=11 with bin=16'h00FF -> out_c=16'hFF00, V=0.
